// File: rtl/io_access_arbiter.sv
// Two-requester round-robin arbiter for a single I/O register port.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE, and a silent I/O section is timed out.
module io_access_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_addr,
  input  logic [63:0] m0_wdata,
  output logic [63:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_addr,
  input  logic [63:0] m1_wdata,
  output logic [63:0] m1_rdata,
  output logic        m1_ack,
  output logic [3:0]  io_rd_addr,
  output logic        io_rd_req,
  input  logic [63:0] io_rd_data,
  input  logic        io_rd_ack,
  output logic [3:0]  io_wr_addr,
  output logic        io_wr_req,
  output logic [63:0] io_wr_data,
  input  logic        io_wr_ack,
  output logic        grant,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic        prio;
  logic [7:0]  tcnt;
  logic        lat_we;
  logic        win;
  logic        sel_we;
  logic [3:0]  sel_addr;
  logic [63:0] sel_wdata;
  logic        ack_hit;

  // prio names the requester that wins a tie; a lone requester wins regardless.
  always_comb begin
    win       = (m0_req && m1_req) ? prio : m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    ack_hit   = lat_we ? io_wr_ack : io_rd_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      tcnt       <= 8'd0;
      lat_we     <= 1'b0;
      m0_rdata   <= 64'd0;
      m1_rdata   <= 64'd0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      io_rd_addr <= 4'd0;
      io_rd_req  <= 1'b0;
      io_wr_addr <= 4'd0;
      io_wr_req  <= 1'b0;
      io_wr_data <= 64'd0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      err       <= 1'b0;
      io_rd_req <= 1'b0;
      io_wr_req <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant  <= win;
            prio   <= ~win;
            lat_we <= sel_we;
            busy   <= 1'b1;
            state  <= ISSUE;
            // Strobes are launched here so they are visible for exactly the ISSUE cycle.
            if (sel_we) begin
              io_wr_req  <= 1'b1;
              io_wr_addr <= sel_addr;
              io_wr_data <= sel_wdata;
            end else begin
              io_rd_req  <= 1'b1;
              io_rd_addr <= sel_addr;
            end
          end
        end
        ISSUE: begin
          tcnt  <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          // An ack in the final WAIT cycle still completes normally, without err.
          if (ack_hit || tcnt == 8'(TIMEOUT - 1)) begin
            if (grant) begin
              m1_rdata <= (ack_hit && !lat_we) ? io_rd_data : 64'd0;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= (ack_hit && !lat_we) ? io_rd_data : 64'd0;
              m0_ack   <= 1'b1;
            end
            err   <= ~ack_hit;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_access_arbiter.sv
// Self-checking bench for io_access_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin/timeout model.
module tb_io_access_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [3:0]  io_rd_addr, io_wr_addr;
  logic        io_rd_req, io_wr_req, io_rd_ack, io_wr_ack;
  logic [63:0] io_rd_data, io_wr_data;
  logic        grant, busy, err;

  int checks = 0;
  int fails  = 0;

  // Requester-side model: what each master is currently asking for.
  bit          pend[2];
  logic        pwe[2];
  logic [3:0]  paddr[2];
  logic [63:0] pwd[2];
  // Reference state: who was served last and what each requester last received.
  bit          last_served;
  logic [63:0] exp_rdata[2];

  io_access_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .io_rd_addr(io_rd_addr), .io_rd_req(io_rd_req), .io_rd_data(io_rd_data),
    .io_rd_ack(io_rd_ack),
    .io_wr_addr(io_wr_addr), .io_wr_req(io_wr_req), .io_wr_data(io_wr_data),
    .io_wr_ack(io_wr_ack),
    .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_reqs();
    m0_req = pend[0]; m0_we = pwe[0]; m0_addr = paddr[0]; m0_wdata = pwd[0];
    m1_req = pend[1]; m1_we = pwe[1]; m1_addr = paddr[1]; m1_wdata = pwd[1];
  endtask

  task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [63:0] d);
    pend[i] = 1'b1; pwe[i] = we; paddr[i] = a; pwd[i] = d;
    apply_reqs();
  endtask

  task automatic model_reset();
    last_served  = 1'b1;
    exp_rdata[0] = 64'd0;
    exp_rdata[1] = 64'd0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    apply_reqs();
  endtask

  // One full access, entered in an IDLE cycle with at least one request pending.
  // d = WAIT cycle (0-based) in which the matching ack is driven; d >= TO means never.
  // noise drives ignorable acks in ISSUE and wrong-direction acks in WAIT.
  task automatic test_transaction(input int d, input bit noise, input logic [63:0] rd);
    int          g;
    bit          exp_err;
    bit          done;
    logic        we;
    logic [3:0]  a;
    logic [63:0] wd;
    g  = (pend[0] && pend[1]) ? int'(!last_served) : (pend[1] ? 1 : 0);
    we = pwe[g]; a = paddr[g]; wd = pwd[g];
    last_served = g[0];
    @(posedge clk); #1;
    checks++;
    if ({busy, grant} !== {1'b1, g[0]}) begin
      fails++;
      $display("[TB] FAIL issue_grant: got busy=%0b grant=%0b, want busy=1 grant=%0d", busy, grant, g);
    end
    checks++;
    if (we) begin
      if ({io_rd_req, io_wr_req, io_wr_addr, io_wr_data} !== {1'b0, 1'b1, a, wd}) begin
        fails++;
        $display("[TB] FAIL issue_write: got rd=%0b wr=%0b addr=%h data=%h, want rd=0 wr=1 addr=%h data=%h",
                 io_rd_req, io_wr_req, io_wr_addr, io_wr_data, a, wd);
      end
    end else begin
      if ({io_rd_req, io_wr_req, io_rd_addr} !== {1'b1, 1'b0, a}) begin
        fails++;
        $display("[TB] FAIL issue_read: got rd=%0b wr=%0b addr=%h, want rd=1 wr=0 addr=%h",
                 io_rd_req, io_wr_req, io_rd_addr, a);
      end
    end
    io_rd_ack = noise & ~we;
    io_wr_ack = noise & we;
    @(posedge clk); #1;
    done = 1'b0;
    for (int w = 0; w < TO && !done; w++) begin
      io_rd_ack  = 1'b0;
      io_wr_ack  = 1'b0;
      io_rd_data = {$urandom, $urandom};
      if (w == d) begin
        if (we) io_wr_ack = 1'b1;
        else begin
          io_rd_ack  = 1'b1;
          io_rd_data = rd;
        end
      end else if (noise) begin
        if (we) io_rd_ack = 1'b1;
        else    io_wr_ack = 1'b1;
      end
      @(posedge clk); #1;
      if (w == d || w == TO - 1) begin
        done         = 1'b1;
        exp_err      = (w != d);
        exp_rdata[g] = (w == d && !we) ? rd : 64'd0;
        checks++;
        if ({m0_ack, m1_ack, err, io_rd_req, io_wr_req, busy} !== {g == 0, g == 1, exp_err, 3'b001}) begin
          fails++;
          $display("[TB] FAIL done_flags: got m0_ack=%0b m1_ack=%0b err=%0b rd=%0b wr=%0b busy=%0b, want ack to m%0d err=%0b busy=1",
                   m0_ack, m1_ack, err, io_rd_req, io_wr_req, busy, g, exp_err);
        end
        checks++;
        if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1]) begin
          fails++;
          $display("[TB] FAIL done_rdata: got m0=%h m1=%h, want m0=%h m1=%h",
                   m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
        end
      end else begin
        checks++;
        if ({m0_ack, m1_ack, err, io_rd_req, io_wr_req, busy} !== 6'b000001) begin
          fails++;
          $display("[TB] FAIL wait_quiet: got m0_ack=%0b m1_ack=%0b err=%0b rd=%0b wr=%0b busy=%0b at wait %0d, want 000001",
                   m0_ack, m1_ack, err, io_rd_req, io_wr_req, busy, w);
        end
      end
    end
    pend[g] = 1'b0;
    apply_reqs();
    io_rd_ack = 1'b0;
    io_wr_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, m0_ack, m1_ack, err} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL back_to_idle: got busy=%0b m0_ack=%0b m1_ack=%0b err=%0b, want all 0",
               busy, m0_ack, m1_ack, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_rd_ack = 1'b0; io_wr_ack = 1'b0; io_rd_data = 64'd0;
    pwe[0] = 1'b0; pwe[1] = 1'b0; paddr[0] = 4'd0; paddr[1] = 4'd0; pwd[0] = 64'd0; pwd[1] = 64'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m0_rdata, m1_rdata, m0_ack, m1_ack, io_rd_addr, io_rd_req, io_wr_addr, io_wr_req,
         io_wr_data, grant, busy, err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got nonzero output(s) busy=%0b grant=%0b m0_rdata=%h io_wr_data=%h, want all 0",
               busy, grant, m0_rdata, io_wr_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 4'h9, 64'd0);
    test_transaction(0, 1'b0, 64'h5A);
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b0, 4'h1, 64'd0);
    set_req(1, 1'b1, 4'h2, 64'h1111);
    for (int k = 0; k < 4; k++) begin
      test_transaction(1, 1'b0, 64'hC0DE_0000 + 64'(k));
      if (!pend[0]) set_req(0, 1'b0, 4'(k + 3), 64'd0);
      if (!pend[1]) set_req(1, 1'b1, 4'(k + 7), 64'h2222 + 64'(k));
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    apply_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_write_timeout();
    set_req(1, 1'b1, 4'h8, 64'hFF);
    test_transaction(1000, 1'b0, 64'd0);
  endtask

  task automatic test_ack_at_expiry();
    set_req(0, 1'b0, 4'h3, 64'd0);
    test_transaction(TO - 1, 1'b0, 64'hDEAD_BEEF_0123_4567);
  endtask

  task automatic test_wrong_dir_ack();
    set_req(0, 1'b0, 4'h6, 64'd0);
    test_transaction(2, 1'b1, 64'h0F0F_1234);
    set_req(1, 1'b1, 4'hA, 64'hABCD);
    test_transaction(3, 1'b1, 64'd0);
  endtask

  task automatic test_reset_mid_wait();
    set_req(0, 1'b0, 4'h4, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    io_rd_ack  = 1'b1;
    io_rd_data = 64'h7777;
    @(posedge clk); #1;
    io_rd_ack = 1'b0;
    checks++;
    if ({m0_rdata, m1_rdata, m0_ack, m1_ack, io_rd_addr, io_rd_req, io_wr_addr, io_wr_req,
         io_wr_data, grant, busy, err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_wait: got m0_ack=%0b m1_ack=%0b busy=%0b err=%0b m0_rdata=%h, want all 0",
               m0_ack, m1_ack, busy, err, m0_rdata);
    end
    set_req(0, 1'b0, 4'h5, 64'd0);
    set_req(1, 1'b0, 4'h6, 64'd0);
    test_transaction(0, 1'b0, 64'h55);
    test_transaction(0, 1'b0, 64'h66);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'($urandom), 4'($urandom), {$urandom, $urandom});
      if (!pend[0] && !pend[1]) begin
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
          fails++;
          $display("[TB] FAIL idle_no_req: got busy=%0b, want 0", busy);
        end
      end else begin
        test_transaction($urandom_range(0, TO + 3), 1'($urandom), {$urandom, $urandom});
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_read();
    test_write_timeout();
    test_ack_at_expiry();
    test_wrong_dir_ack();
    test_reset_mid_wait();
    test_random(60);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
